pipeline_control: RTL
=====================

PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, width of the stall-cycle counter.
REQ-002 SHALL have port CLK  in  1  pipeline clock.
REQ-003 SHALL have port RST  in  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port ihit  in  1  instruction fetch completes this cycle.
REQ-005 SHALL have port dhit  in  1  data access in MEM completes this cycle.
REQ-006 SHALL have port mem_dREN  in  1  MEM-stage instruction reads data memory.
REQ-007 SHALL have port mem_dWEN  in  1  MEM-stage instruction writes data memory.
REQ-008 SHALL have port ex_memread  in  1  EX-stage instruction is a load.
REQ-009 SHALL have port ex_rt  in  5  load destination register in EX.
REQ-010 SHALL have port id_rs  in  5  ID-stage source register 1.
REQ-011 SHALL have port id_rt  in  5  ID-stage source register 2.
REQ-012 SHALL have port id_branch  in  1  ID-stage instruction is a branch, compared in ID.
REQ-013 SHALL have port branch_taken  in  1  ID-stage branch or jump redirects the PC.
REQ-014 SHALL have port halt_mem  in  1  halt instruction has reached MEM.
REQ-015 SHALL have port pc_en  out  1  PC update enable.
REQ-016 SHALL have port ifid_en  out  1  IF/ID latch enable.
REQ-017 SHALL have port idex_en  out  1  ID/EX latch enable.
REQ-018 SHALL have port back_en  out  1  EX/MEM and MEM/WB latch enable.
REQ-019 SHALL have port ifid_flush  out  1  IF/ID loads a bubble.
REQ-020 SHALL have port idex_flush  out  1  ID/EX loads a bubble.
REQ-021 SHALL have port halted  out  1  sticky halt indication.
REQ-022 SHALL have port stall_cycles  out  STALL_CNT_W  count of cycles with pc_en=0.

Function
REQ-023 SHALL implement the registered FSM states RUN, LU_STALL, MEMWAIT and HALTED; all outputs are combinational from the state and the inputs.
REQ-024 SHALL define dwait = (mem_dREN|mem_dWEN) & !dhit, and lu = ex_memread & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
REQ-025 SHALL evaluate RUN with priority halt_mem > dwait > lu > branch_taken > !ihit.
REQ-026 SHALL, in RUN on halt_mem, drive all enables 0 and go to HALTED; HALTED is left only by RST.
REQ-027 SHALL, on dwait in RUN, drive all enables and flushes 0 and go to MEMWAIT.
REQ-028 SHALL, in MEMWAIT, hold all enables 0 until dhit=1; in the dhit cycle it drives all enables 1 and returns to the saved return state (RUN, or LU_STALL with its remaining count).
REQ-029 SHALL, on lu in RUN, drive pc_en=0, ifid_en=0, idex_flush=1 and back_en=1, and load the bubble counter with 0 if id_branch=0 or 1 if id_branch=1; a non-zero count moves to LU_STALL, a zero count stays in RUN.
REQ-030 SHALL, in LU_STALL, repeat the lu outputs of REQ-029 and decrement the bubble counter; it returns to RUN when the counter reaches 0, giving 1 bubble for ALU consumers and 2 for ID-stage branches.
REQ-031 SHALL, on dwait during LU_STALL, freeze all stages, save the remaining bubble count, and enter MEMWAIT.
REQ-032 SHALL, on branch_taken with pc_en=1, assert ifid_flush=1; branch_taken is ignored whenever ifid_en=0.
REQ-033 SHALL, on !ihit with no higher-priority event, drive pc_en=0, ifid_flush=1 and all other enables 1.
REQ-034 SHALL increment stall_cycles in every non-HALTED cycle with pc_en=0, saturating at all-ones.
REQ-035 SHALL never assert a latch enable and its flush in the same cycle unless the flush wins; flush has precedence.

Reset
REQ-036 SHALL, on RST, set the state to RUN, the bubble counter and saved return state to 0/RUN, stall_cycles to 0 and halted to 0, including when RST arrives mid-MEMWAIT or mid-LU_STALL.
REQ-037 SHALL, in the reset cycle, drive all enables 0 and all flushes 0.

Structure
REQ-038 SHALL place the state enum pctl_state_t and the register-index width constant in the shared package pipeline_pkg.
REQ-039 SHALL place the lu comparison in the combinational sub-module load_use_detect.

Verification
REQ-040 SHALL verify: ex_memread=1, ex_rt=5, id_rs=5, id_branch=0 -> one cycle of pc_en=0 and idex_flush=1, then RUN; stall_cycles=1.
REQ-041 SHALL verify: the same case with id_branch=1 -> two consecutive bubble cycles, then RUN; stall_cycles=2.
REQ-042 SHALL verify: mem_dREN=1, dhit=0 for 3 cycles then 1 -> all enables 0 for 3 cycles and 1 in the dhit cycle; stall_cycles=3.
REQ-043 SHALL verify: dwait arrives in the first LU_STALL cycle of a branch case -> freeze until dhit, then exactly 1 more bubble.
REQ-044 SHALL verify: halt_mem=1 together with branch_taken=1 -> HALTED, halted=1 held for 10 cycles, and RST returns to RUN with stall_cycles=0.
REQ-045 SHALL verify: STALL_CNT_W=4 with 20 stall cycles -> stall_cycles holds at 15.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Controller states and register-index width used by the top and the load-use detector.
package pipeline_pkg;

    localparam int REG_IDX_W = 5;
    localparam int BUBBLE_W  = 2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEMWAIT  = 2'd2,
        HALTED   = 2'd3
    } pctl_state_t;

endpackage

// File: rtl/pipeline_control_load_use_detect.sv
// Load-use hazard detector: an EX-stage load whose destination feeds an ID-stage source.
// Purely combinational, no latency; register 0 never creates a hazard.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic                 ex_memread,
    input  logic [REG_IDX_W-1:0] ex_rt,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    output logic                 lu
);

    assign lu = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_control.sv
// Pipeline stall/flush controller: registered state, combinational enables/flushes, zero latency.
// Freezes every stage on a data-memory wait; load-use inserts bubbles while the back end drains.
module pipeline_control
    import pipeline_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   mem_dREN,
    input  logic                   mem_dWEN,
    input  logic                   ex_memread,
    input  logic [REG_IDX_W-1:0]   ex_rt,
    input  logic [REG_IDX_W-1:0]   id_rs,
    input  logic [REG_IDX_W-1:0]   id_rt,
    input  logic                   id_branch,
    input  logic                   branch_taken,
    input  logic                   halt_mem,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   back_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    pctl_state_t         state, state_nxt;
    pctl_state_t         ret_state, ret_state_nxt;
    logic [BUBBLE_W-1:0] bubble_cnt, bubble_cnt_nxt;
    logic                lu;
    logic                dwait;

    load_use_detect u_lu (
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .lu         (lu)
    );

    assign dwait  = (mem_dREN || mem_dWEN) && !dhit;
    assign halted = (state == HALTED);

    always_comb begin
        state_nxt      = state;
        ret_state_nxt  = ret_state;
        bubble_cnt_nxt = bubble_cnt;
        pc_en          = 1'b0;
        ifid_en        = 1'b0;
        idex_en        = 1'b0;
        back_en        = 1'b0;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;

        if (!RST) begin
            case (state)
                RUN: begin
                    if (halt_mem) begin
                        state_nxt = HALTED;
                    end else if (dwait) begin
                        state_nxt      = MEMWAIT;
                        ret_state_nxt  = RUN;
                        bubble_cnt_nxt = '0;
                    end else if (lu) begin
                        // Hold PC and IF/ID, drop a bubble into ID/EX; branches compared in ID need one more.
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                        back_en    = 1'b1;
                        if (id_branch) begin
                            bubble_cnt_nxt = BUBBLE_W'(1);
                            state_nxt      = LU_STALL;
                        end else begin
                            bubble_cnt_nxt = '0;
                        end
                    end else if (branch_taken) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        back_en    = 1'b1;
                        ifid_flush = 1'b1;
                    end else if (!ihit) begin
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        back_en    = 1'b1;
                        ifid_flush = 1'b1;
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                        idex_en = 1'b1;
                        back_en = 1'b1;
                    end
                end
                LU_STALL: begin
                    if (halt_mem) begin
                        state_nxt = HALTED;
                    end else if (dwait) begin
                        // Remaining bubble count stays in bubble_cnt across the wait.
                        state_nxt     = MEMWAIT;
                        ret_state_nxt = LU_STALL;
                    end else begin
                        idex_en        = 1'b1;
                        idex_flush     = 1'b1;
                        back_en        = 1'b1;
                        bubble_cnt_nxt = bubble_cnt - BUBBLE_W'(1);
                        if (bubble_cnt <= BUBBLE_W'(1)) begin
                            state_nxt = RUN;
                        end
                    end
                end
                MEMWAIT: begin
                    if (dhit) begin
                        pc_en     = 1'b1;
                        ifid_en   = 1'b1;
                        idex_en   = 1'b1;
                        back_en   = 1'b1;
                        state_nxt = ret_state;
                    end
                end
                HALTED: begin
                    state_nxt = HALTED;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= RUN;
            ret_state    <= RUN;
            bubble_cnt   <= '0;
            stall_cycles <= '0;
        end else begin
            state      <= state_nxt;
            ret_state  <= ret_state_nxt;
            bubble_cnt <= bubble_cnt_nxt;
            if ((state != HALTED) && !pc_en && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
            end
        end
    end

endmodule
